// File: rtl/tz_arb_pkg.sv
// Shared types and helpers for the trailing-zero round-robin arbiter.
// Holds the FSM state type, the default sizing and the tz_count helper.
package tz_arb_pkg;

   localparam int unsigned DefaultN       = 8;
   localparam int unsigned DefaultMaxHold = 16;

   typedef enum logic {
      StIdle,
      StBusy
   } state_e;

   // Returns the number of trailing zeros of the low n bits of v, or n when they are all zero.
   // The scan is fixed at 32 bits, so n must be 32 or less.
   function automatic int unsigned tz_count(input logic [31:0] v, input int unsigned n);
      int unsigned r;
      r = n;
      for (int i = 31; i >= 0; i--) begin
         if (i < int'(n) && v[i]) begin
            r = unsigned'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/tz_count_unit.sv
// Combinational trailing-zero counter: output is N when the input vector is all zero.
module tz_count_unit
   import tz_arb_pkg::*;
#(
   parameter int unsigned N     = DefaultN,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0] vec_i,
   output logic [IDX_W:0] count_o
);

   localparam int unsigned CntW = IDX_W + 1;

   assign count_o = CntW'(tz_count(32'(vec_i), N));

endmodule

// File: rtl/tz_rr_arbiter.sv
// Round-robin arbiter with grant hold, done/request-drop release and forced revoke on timeout.
// Winner is the lowest request at or above the rotating pointer, else the lowest request overall.
module tz_rr_arbiter
   import tz_arb_pkg::*;
#(
   parameter int unsigned N        = DefaultN,
   parameter int unsigned IDX_W    = $clog2(N),
   parameter int unsigned MAX_HOLD = DefaultMaxHold
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             done,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             timeout
);

   localparam int unsigned HoldW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);
   localparam logic [IDX_W-1:0] IdxLast  = IDX_W'(N - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic [N-1:0]     grant_q, grant_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;

   logic [N-1:0]     masked;
   logic [IDX_W:0]   tz_masked, tz_req;
   logic [IDX_W-1:0] sel;
   logic             at_limit, req_drop;

   always_comb begin
      masked = '0;
      for (int i = 0; i < int'(N); i++) begin
         masked[i] = req[i] && (i >= int'(ptr_q));
      end
   end

   tz_count_unit #(.N(N), .IDX_W(IDX_W)) u_tz_masked (
      .vec_i   (masked),
      .count_o (tz_masked)
   );

   tz_count_unit #(.N(N), .IDX_W(IDX_W)) u_tz_req (
      .vec_i   (req),
      .count_o (tz_req)
   );

   assign sel      = (|masked) ? tz_masked[IDX_W-1:0] : tz_req[IDX_W-1:0];
   assign at_limit = (hold_q == HoldLast);
   assign req_drop = !req[idx_q];

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      grant_d   = grant_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            grant_d = '0;
            valid_d = 1'b0;
            if (|req) begin
               grant_d = N'(1) << sel;
               idx_d   = sel;
               valid_d = 1'b1;
               hold_d  = '0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (done || req_drop || at_limit) begin
               grant_d   = '0;
               valid_d   = 1'b0;
               state_d   = StIdle;
               ptr_d     = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
               // Timeout only when the limit alone forced the release.
               timeout_d = at_limit && !done && !req_drop;
            end else if (!at_limit) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         hold_q    <= '0;
         grant_q   <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         grant_q   <= grant_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = idx_q;
   assign grant_valid = valid_q;
   assign timeout     = timeout_q;

endmodule
